// File: rtl/dcache_pkg.sv
// Shared types for the data-cache memory-side write buffer.
// Entry layout and FSM state encoding used by dcache_wbuf and wbuf_fifo.
package dcache_pkg;
  localparam int DC_AW = 32;
  localparam int DC_DW = 32;

  typedef struct packed {
    logic [DC_AW-3:0]   addr;
    logic [DC_DW-1:0]   data;
    logic [DC_DW/8-1:0] strb;
  } wbuf_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_BUS,
    RD_BUS,
    HAZ_DRAIN,
    RD_DONE
  } wbuf_state_e;
endpackage

// File: rtl/wbuf_fifo.sv
// Write-buffer storage: circular FIFO with wrap-bit pointers
// and a parallel word-address match against all valid entries.
module wbuf_fifo
  import dcache_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  wbuf_entry_t      din_i,
  input  logic             pop_i,
  output wbuf_entry_t      head_o,
  input  logic [DC_AW-3:0] q_addr_i,
  output logic             match_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o
);
  wbuf_entry_t       mem_q [DEPTH];
  logic [CW-1:0]     wr_q;
  logic [CW-1:0]     rd_q;
  logic [DEPTH-1:0]  vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[PW-1:0]] <= din_i;
  end

  assign count_o = wr_q - rd_q;
  assign empty_o = (count_o == '0);
  assign full_o  = (count_o == CW'(DEPTH));
  assign head_o  = mem_q[rd_q[PW-1:0]];

  // Slot i is live when its distance from the head is below the count.
  always_comb begin
    vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      vld[i] = {1'b0, PW'(i) - rd_q[PW-1:0]} < count_o;
    end
  end

  always_comb begin
    match_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && mem_q[i].addr == q_addr_i) match_o = 1'b1;
    end
  end
endmodule

// File: rtl/dcache_wbuf.sv
// Memory-side write buffer for the data cache: posts stores,
// drains them in order, and lets refills bypass unless they hit.
module dcache_wbuf
  import dcache_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int AW    = DC_AW,
  parameter  int DW    = DC_DW,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          DM_enable,
  input  logic          DM_write,
  input  logic [AW-1:0] DM_address,
  input  logic [DW-1:0] DM_wdata,
  input  logic [DW/8-1:0] DM_wstrb,
  output logic          ready,
  output logic [DW-1:0] DataIn,
  output logic          mem_req,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          wbuf_empty,
  output logic [CW-1:0] wbuf_count
);
  wbuf_state_e   state_q;
  logic          from_haz_q;
  logic          ready_q;
  logic [DW-1:0] data_q;

  logic          rd_pend;
  logic          st_acc;
  logic          pop;
  logic          hit;
  logic          full;
  logic          empty;
  wbuf_entry_t   head;
  wbuf_entry_t   din;
  logic          unused;

  assign unused  = ^DM_address[1:0];
  // The ready cycle still shows the finished request; ignore it.
  assign rd_pend = DM_enable & ~DM_write & ~ready_q;
  assign st_acc  = DM_enable & DM_write & ~ready_q & ~full;
  assign pop     = (state_q == WR_BUS) & mem_ack;

  assign din.addr = DM_address[AW-1:2];
  assign din.data = DM_wdata;
  assign din.strb = DM_wstrb;

  wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (st_acc),
    .din_i    (din),
    .pop_i    (pop),
    .head_o   (head),
    .q_addr_i (DM_address[AW-1:2]),
    .match_o  (hit),
    .empty_o  (empty),
    .full_o   (full),
    .count_o  (wbuf_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      from_haz_q <= 1'b0;
      ready_q    <= 1'b0;
      data_q     <= '0;
      mem_req    <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
    end else begin
      ready_q <= st_acc | ((state_q == RD_BUS) & mem_ack);
      unique case (state_q)
        IDLE: begin
          if (rd_pend && hit) begin
            state_q <= HAZ_DRAIN;
          end else if (rd_pend) begin
            state_q   <= RD_BUS;
            mem_req   <= 1'b1;
            mem_write <= 1'b0;
            mem_addr  <= {DM_address[AW-1:2], 2'b00};
            mem_wstrb <= '0;
          end else if (!empty) begin
            state_q    <= WR_BUS;
            from_haz_q <= 1'b0;
            mem_req    <= 1'b1;
            mem_write  <= 1'b1;
            mem_addr   <= {head.addr, 2'b00};
            mem_wdata  <= head.data;
            mem_wstrb  <= head.strb;
          end
        end
        HAZ_DRAIN: begin
          if (!rd_pend) begin
            state_q <= IDLE;
          end else if (hit) begin
            state_q    <= WR_BUS;
            from_haz_q <= 1'b1;
            mem_req    <= 1'b1;
            mem_write  <= 1'b1;
            mem_addr   <= {head.addr, 2'b00};
            mem_wdata  <= head.data;
            mem_wstrb  <= head.strb;
          end else begin
            state_q   <= RD_BUS;
            mem_req   <= 1'b1;
            mem_write <= 1'b0;
            mem_addr  <= {DM_address[AW-1:2], 2'b00};
            mem_wstrb <= '0;
          end
        end
        WR_BUS: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_write <= 1'b0;
            state_q   <= from_haz_q ? HAZ_DRAIN : IDLE;
          end
        end
        RD_BUS: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            data_q  <= mem_rdata;
            state_q <= RD_DONE;
          end
        end
        RD_DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready      = ready_q;
  assign DataIn     = data_q;
  assign wbuf_empty = empty;
endmodule
